// File: rtl/norm_share_arbiter.sv
// Two-stage round-robin scheduler sharing one Normalizer between two FMA lanes.
// Stage 1 registers the granted lane's operands; stage 2 captures Normalizer results with a lane tag.
`timescale 1ns/1ps
module norm_share_arbiter #(
  parameter int PARM_LEADONE_WIDTH = 7,
  parameter int PARM_EXP           = 8,
  parameter int PARM_MANT          = 23
) (
  input  logic                                Clk_i,
  input  logic                                Rst_n_i,
  input  logic [1:0]                          Req_valid_i,
  output logic [1:0]                          Req_ready_o,
  input  logic [2*(3*PARM_MANT+5)-1:0]        Req_mant_i,
  input  logic [2*(PARM_EXP+2)-1:0]           Req_exp_i,
  input  logic [2*PARM_LEADONE_WIDTH-1:0]     Req_shift_i,
  input  logic [1:0]                          Req_mvsign_i,
  output logic [3*PARM_MANT+4:0]              Norm_mant_o,
  output logic [PARM_EXP+1:0]                 Norm_exp_o,
  output logic [PARM_LEADONE_WIDTH-1:0]       Norm_shift_o,
  output logic                                Norm_mvsign_o,
  input  logic [3*PARM_MANT+4:0]              Norm_mant_norm_i,
  input  logic [PARM_EXP+1:0]                 Norm_exp_norm_i,
  input  logic [PARM_EXP+1:0]                 Norm_exp_mone_i,
  input  logic [PARM_EXP+1:0]                 Norm_exp_maxrs_i,
  input  logic [3*PARM_MANT+6:0]              Norm_rs_mant_i,
  output logic                                Res_valid_o,
  input  logic                                Res_ready_i,
  output logic                                Res_lane_o,
  output logic [3*PARM_MANT+4:0]              Res_mant_norm_o,
  output logic [PARM_EXP+1:0]                 Res_exp_norm_o,
  output logic [PARM_EXP+1:0]                 Res_exp_mone_o,
  output logic [PARM_EXP+1:0]                 Res_exp_maxrs_o,
  output logic [3*PARM_MANT+6:0]              Res_rs_mant_o,
  output logic                                Busy_o
);

  localparam int MW = 3*PARM_MANT+5;
  localparam int EW = PARM_EXP+2;
  localparam int LW = PARM_LEADONE_WIDTH;
  localparam int RW = 3*PARM_MANT+7;

  logic          s1_v, s1_lane, s2_v, s2_lane, rr_ptr;
  logic [MW-1:0] s1_mant;
  logic [EW-1:0] s1_exp;
  logic [LW-1:0] s1_shift;
  logic          s1_mvsign;
  logic [MW-1:0] s2_mant_norm;
  logic [EW-1:0] s2_exp_norm, s2_exp_mone, s2_exp_maxrs;
  logic [RW-1:0] s2_rs_mant;

  logic          s2_adv, s1_adv, gnt, accept;
  logic [1:0]    ready;

  // Ready is forced low while reset is held, even though the cleared pipe would otherwise advance.
  always_comb begin
    s2_adv = !s2_v || Res_ready_i;
    s1_adv = !s1_v || s2_adv;
    gnt    = (&Req_valid_i) ? rr_ptr : Req_valid_i[1];
    ready  = '0;
    if (Rst_n_i && (|Req_valid_i) && s1_adv) ready[gnt] = 1'b1;
    accept = |(ready & Req_valid_i);
  end

  always_ff @(posedge Clk_i or negedge Rst_n_i) begin
    if (!Rst_n_i) begin
      rr_ptr    <= 1'b0;
      s1_v      <= 1'b0;
      s1_lane   <= 1'b0;
      s1_mant   <= '0;
      s1_exp    <= '0;
      s1_shift  <= '0;
      s1_mvsign <= 1'b0;
    end else begin
      if (accept) rr_ptr <= ~gnt;
      if (s1_adv) begin
        s1_v <= accept;
        if (accept) begin
          s1_lane   <= gnt;
          s1_mant   <= gnt ? Req_mant_i[2*MW-1:MW]   : Req_mant_i[MW-1:0];
          s1_exp    <= gnt ? Req_exp_i[2*EW-1:EW]    : Req_exp_i[EW-1:0];
          s1_shift  <= gnt ? Req_shift_i[2*LW-1:LW]  : Req_shift_i[LW-1:0];
          s1_mvsign <= gnt ? Req_mvsign_i[1]         : Req_mvsign_i[0];
        end
      end
    end
  end

  always_ff @(posedge Clk_i or negedge Rst_n_i) begin
    if (!Rst_n_i) begin
      s2_v         <= 1'b0;
      s2_lane      <= 1'b0;
      s2_mant_norm <= '0;
      s2_exp_norm  <= '0;
      s2_exp_mone  <= '0;
      s2_exp_maxrs <= '0;
      s2_rs_mant   <= '0;
    end else if (s2_adv) begin
      s2_v <= s1_v;
      if (s1_v) begin
        s2_lane      <= s1_lane;
        s2_mant_norm <= Norm_mant_norm_i;
        s2_exp_norm  <= Norm_exp_norm_i;
        s2_exp_mone  <= Norm_exp_mone_i;
        s2_exp_maxrs <= Norm_exp_maxrs_i;
        s2_rs_mant   <= Norm_rs_mant_i;
      end
    end
  end

  assign Req_ready_o     = ready;
  assign Norm_mant_o     = s1_mant;
  assign Norm_exp_o      = s1_exp;
  assign Norm_shift_o    = s1_shift;
  assign Norm_mvsign_o   = s1_mvsign;
  assign Res_valid_o     = s2_v;
  assign Res_lane_o      = s2_lane;
  assign Res_mant_norm_o = s2_mant_norm;
  assign Res_exp_norm_o  = s2_exp_norm;
  assign Res_exp_mone_o  = s2_exp_mone;
  assign Res_exp_maxrs_o = s2_exp_maxrs;
  assign Res_rs_mant_o   = s2_rs_mant;
  assign Busy_o          = s1_v | s2_v;

endmodule

// File: tb/tb_norm_share_arbiter.sv
// Bench for norm_share_arbiter: stub Normalizer, queue-based reference model, directed scenarios.
`timescale 1ns/1ps
module tb_norm_share_arbiter;

  logic         clk, rst_n;
  logic [1:0]   req_valid, req_ready;
  logic [73:0]  l_mant [2];
  logic [9:0]   l_exp  [2];
  logic [6:0]   l_shift[2];
  logic [1:0]   l_mv;
  logic [73:0]  n_mant, n_mant_norm, r_mant_norm;
  logic [9:0]   n_exp, n_exp_norm, n_exp_mone, n_exp_maxrs;
  logic [9:0]   r_exp_norm, r_exp_mone, r_exp_maxrs;
  logic [6:0]   n_shift;
  logic         n_mv, r_valid, r_lane, res_ready, busy;
  logic [75:0]  n_rs, r_rs;

  norm_share_arbiter #(.PARM_LEADONE_WIDTH(7), .PARM_EXP(8), .PARM_MANT(23)) dut (
    .Clk_i(clk), .Rst_n_i(rst_n),
    .Req_valid_i(req_valid), .Req_ready_o(req_ready),
    .Req_mant_i({l_mant[1], l_mant[0]}), .Req_exp_i({l_exp[1], l_exp[0]}),
    .Req_shift_i({l_shift[1], l_shift[0]}), .Req_mvsign_i(l_mv),
    .Norm_mant_o(n_mant), .Norm_exp_o(n_exp), .Norm_shift_o(n_shift), .Norm_mvsign_o(n_mv),
    .Norm_mant_norm_i(n_mant_norm), .Norm_exp_norm_i(n_exp_norm), .Norm_exp_mone_i(n_exp_mone),
    .Norm_exp_maxrs_i(n_exp_maxrs), .Norm_rs_mant_i(n_rs),
    .Res_valid_o(r_valid), .Res_ready_i(res_ready), .Res_lane_o(r_lane),
    .Res_mant_norm_o(r_mant_norm), .Res_exp_norm_o(r_exp_norm), .Res_exp_mone_o(r_exp_mone),
    .Res_exp_maxrs_o(r_exp_maxrs), .Res_rs_mant_o(r_rs), .Busy_o(busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        lane;
    logic [73:0] mant;
    logic [9:0]  exp;
    logic [6:0]  shift;
    logic        mv;
  } item_t;

  typedef struct {
    logic [73:0] mn;
    logic [9:0]  en, em, ex;
    logic [75:0] rs;
  } res_t;

  // Stand-in Normalizer: exponent bit 9 flags overflow and bypasses the shift.
  function automatic res_t norm_ref(input logic [73:0] m, input logic [9:0] e,
                                    input logic [6:0] s, input logic mv);
    res_t r;
    r.mn = e[9] ? m : (m << s);
    r.en = e[9] ? 10'd0 : (e - {3'd0, s});
    r.em = r.en - 10'd1;
    r.ex = e + 10'd1;
    r.rs = {m, 1'b0, mv};
    return r;
  endfunction

  res_t stub;
  always_comb begin
    stub        = norm_ref(n_mant, n_exp, n_shift, n_mv);
    n_mant_norm = stub.mn;
    n_exp_norm  = stub.en;
    n_exp_mone  = stub.em;
    n_exp_maxrs = stub.ex;
    n_rs        = stub.rs;
  end

  int checks = 0;
  int errors = 0;

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, req, $time);
    end
  endtask

  // Reference model: in-flight items oldest first; m_out says the head has reached the result register.
  item_t q[$];
  int    m_out;
  logic  m_rr;
  int    acc_log[$];
  int    res_log[$];

  function automatic logic [1:0] model_ready();
    logic g;
    logic [1:0] r;
    r = 2'b00;
    if (rst_n && req_valid != 2'b00 && !(q.size() == 2 && !res_ready)) begin
      g = (req_valid == 2'b11) ? m_rr : req_valid[1];
      r[g] = 1'b1;
    end
    return r;
  endfunction

  initial begin : compare
    res_t  e;
    item_t it, mid;
    logic [1:0] er;
    q.delete(); m_out = 0; m_rr = 1'b0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        q.delete(); m_out = 0; m_rr = 1'b0;
        chk("rst_res_valid", {127'd0, r_valid}, 128'd0);
        chk("rst_busy", {127'd0, busy}, 128'd0);
        chk("rst_ready", {126'd0, req_ready}, 128'd0);
        chk("rst_norm_mant", {54'd0, n_mant}, 128'd0);
        chk("rst_res_exp", {118'd0, r_exp_norm}, 128'd0);
      end else begin
        er = model_ready();
        chk("req_ready", {126'd0, req_ready}, {126'd0, er});
        chk("busy", {127'd0, busy}, {127'd0, q.size() > 0});
        chk("res_valid", {127'd0, r_valid}, {127'd0, (m_out == 1)});
        if (m_out == 1) begin
          e = norm_ref(q[0].mant, q[0].exp, q[0].shift, q[0].mv);
          chk("res_lane", {127'd0, r_lane}, {127'd0, q[0].lane});
          chk("res_mant_norm", {54'd0, r_mant_norm}, {54'd0, e.mn});
          chk("res_exp_norm", {118'd0, r_exp_norm}, {118'd0, e.en});
          chk("res_exp_mone", {118'd0, r_exp_mone}, {118'd0, e.em});
          chk("res_exp_maxrs", {118'd0, r_exp_maxrs}, {118'd0, e.ex});
          chk("res_rs_mant", {52'd0, r_rs}, {52'd0, e.rs});
        end
        if (q.size() == 2 || (q.size() == 1 && m_out == 0)) begin
          mid = q[q.size()-1];
          chk("norm_mant", {54'd0, n_mant}, {54'd0, mid.mant});
          chk("norm_exp", {118'd0, n_exp}, {118'd0, mid.exp});
          chk("norm_shift", {121'd0, n_shift}, {121'd0, mid.shift});
          chk("norm_mvsign", {127'd0, n_mv}, {127'd0, mid.mv});
        end
        if ((req_valid & req_ready) != 2'b00) acc_log.push_back(req_ready[1] ? 1 : 0);
        if (r_valid && res_ready) res_log.push_back(r_lane ? 1 : 0);
      end
      @(posedge clk);
      if (!rst_n) begin
        q.delete(); m_out = 0; m_rr = 1'b0;
      end else begin
        er = model_ready() & req_valid;
        if (m_out == 1 && res_ready) begin
          void'(q.pop_front());
          m_out = 0;
        end
        if (q.size() > 0) m_out = 1;
        if (er != 2'b00) begin
          it.lane  = er[1];
          it.mant  = l_mant[it.lane];
          it.exp   = l_exp[it.lane];
          it.shift = l_shift[it.lane];
          it.mv    = l_mv[it.lane];
          q.push_back(it);
          m_rr = ~it.lane;
        end
      end
    end
  end

  // Advance n cycles; a lane whose request was taken presents a fresh mantissa next.
  task automatic tick(input int n);
    logic [1:0] a;
    for (int i = 0; i < n; i++) begin
      #1;
      a = req_valid & req_ready;
      @(posedge clk);
      #1;
      for (int k = 0; k < 2; k++) if (a[k]) l_mant[k] = l_mant[k] + 74'd1;
    end
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    req_valid = 2'b00;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    acc_log.delete();
    res_log.delete();
  endtask

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  logic [73:0] saved_mant;

  initial begin : stim
    rst_n = 1'b0;
    req_valid = 2'b00;
    res_ready = 1'b1;
    l_mant[0] = 74'h1234_5678_9ABC_DEF0; l_mant[1] = 74'h0FED_CBA9_8765_4321;
    l_exp[0] = 10'd10; l_exp[1] = 10'd40;
    l_shift[0] = 7'd3; l_shift[1] = 7'd5;
    l_mv = 2'b10;
    repeat (2) @(posedge clk);
    #1;
    chk("reset_res_valid", {127'd0, r_valid}, 128'd0);
    chk("reset_norm_exp", {118'd0, n_exp}, 128'd0);
    rst_n = 1'b1;

    // Single lane-0 request, two-cycle latency.
    tick(1);
    req_valid = 2'b01;
    #1;
    chk("t1_ready", {126'd0, req_ready}, 128'd1);
    tick(1);
    req_valid = 2'b00;
    tick(1);
    #1;
    chk("t1_valid", {127'd0, r_valid}, 128'd1);
    chk("t1_lane", {127'd0, r_lane}, 128'd0);
    chk("t1_exp_norm", {118'd0, r_exp_norm}, 128'd7);
    chk("t1_exp_mone", {118'd0, r_exp_mone}, 128'd6);
    tick(2);

    // Both lanes streaming: strict alternation starting at lane 0.
    do_reset();
    req_valid = 2'b11;
    tick(6);
    req_valid = 2'b00;
    tick(3);
    chk("t2_acc_count", 128'(acc_log.size()), 128'd6);
    chk("t2_res_count", 128'(res_log.size()), 128'd6);
    if (acc_log.size() == 6 && res_log.size() == 6)
      for (int i = 0; i < 6; i++) begin
        chk("t2_grant_seq", 128'(acc_log[i]), 128'(i % 2));
        chk("t2_res_seq", 128'(res_log[i]), 128'(i % 2));
      end

    // Backpressure with lane 1 streaming.
    do_reset();
    res_ready = 1'b0;
    req_valid = 2'b10;
    tick(2);
    #1;
    saved_mant = r_mant_norm;
    chk("t3_full_ready", {126'd0, req_ready}, 128'd0);
    tick(1);
    #1;
    chk("t3_hold_mant", {54'd0, r_mant_norm}, {54'd0, saved_mant});
    chk("t3_full_ready2", {126'd0, req_ready}, 128'd0);
    tick(1);
    res_ready = 1'b1;
    tick(2);
    req_valid = 2'b00;
    tick(4);
    chk("t3_acc_count", 128'(acc_log.size()), 128'd4);
    chk("t3_res_count", 128'(res_log.size()), 128'd4);

    // Lane 0 alone three times, then contention goes to lane 1.
    do_reset();
    req_valid = 2'b01;
    tick(3);
    req_valid = 2'b11;
    tick(2);
    req_valid = 2'b00;
    tick(3);
    chk("t4_acc_count", 128'(acc_log.size()), 128'd5);
    if (acc_log.size() == 5) begin
      chk("t4_first_contended", 128'(acc_log[3]), 128'd1);
      chk("t4_second_contended", 128'(acc_log[4]), 128'd0);
    end

    // Asynchronous reset mid-flight drops the in-flight item.
    do_reset();
    req_valid = 2'b01;
    tick(1);
    req_valid = 2'b00;
    #2;
    rst_n = 1'b0;
    #1;
    chk("t5_res_valid", {127'd0, r_valid}, 128'd0);
    chk("t5_busy", {127'd0, busy}, 128'd0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    tick(4);
    chk("t5_no_result", 128'(res_log.size()), 128'd0);

    // Overflow exponent on lane 1 bypasses normalization.
    do_reset();
    l_mant[1] = 74'h2_ABCD_0123_4567_89AB;
    l_exp[1] = 10'h200;
    saved_mant = l_mant[1];
    req_valid = 2'b10;
    tick(1);
    req_valid = 2'b00;
    tick(1);
    #1;
    chk("t6_valid", {127'd0, r_valid}, 128'd1);
    chk("t6_lane", {127'd0, r_lane}, 128'd1);
    chk("t6_exp_norm", {118'd0, r_exp_norm}, 128'd0);
    chk("t6_mant", {54'd0, r_mant_norm}, {54'd0, saved_mant});
    tick(3);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
